fir_decimator: RTL and testbench
================================

FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_W, 8, sample width, equal to the FIR output width.
- FIFO_DEPTH, 4, output FIFO entries, a power of two and at least 2.
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, sole clock; all state updates on posedge.
- reset, in, 1, asynchronous active-low reset; 0 resets all state immediately.
- in_valid, in, 1, in_data holds a sample this cycle; no backpressure, and every valid sample is accepted.
- in_data, in, DATA_W, unsigned sample from the FIR output y.
- decim_sel, in, 2, decimation factor N: 0 gives 1, 1 gives 2, 2 gives 4, 3 gives 8.
- out_valid, out, 1, FIFO non-empty.
- out_data, out, DATA_W, FIFO head; valid only while out_valid=1.
- out_ready, in, 1, consumer accepts the head when out_valid and out_ready are both 1.
- overflow, out, 1, sticky: a result was dropped.
- overflow_clr, in, 1, clears overflow.
- fifo_count, out, clog2(FIFO_DEPTH)+1, current number of FIFO entries.

Function
REQ-003 The block SHALL average each window of N accepted samples and emit one result per window (block average, decimate by N).
REQ-004 Window start: decim_sel SHALL be latched on the accepted sample whose window count is 0; decim_sel changes mid-window SHALL have no effect until the next window.
REQ-005 Accumulator SHALL be DATA_W+3 bits wide, unsigned, and never overflow (8 x 255 = 2040).
REQ-006 Result SHALL be (acc + in_data of last sample) >> log2(N), truncated (no rounding); the result always fits in DATA_W bits.
REQ-007 Window counter SHALL count from 0 to N-1 on accepted samples only; in_valid=0 cycles SHALL hold state; the counter wraps to 0 and the accumulator clears on the last sample.
REQ-008 States SHALL be IDLE (count=0, acc=0) and ACCUM (count>0):
- IDLE to ACCUM on an accepted sample when N>1.
- ACCUM to IDLE on the accepted sample with count=N-1.
- With N=1, the block stays in IDLE and every sample is a result.
REQ-009 The result SHALL be pushed into the FIFO on the clock edge that accepts the last sample; out_valid rises the next cycle if the FIFO was empty (latency 1 cycle).
REQ-010 A pop SHALL occur on an edge where out_valid and out_ready are both 1; out_ready while empty SHALL be ignored.
REQ-011 Push and pop on the same edge SHALL both succeed, with count unchanged, including when the FIFO is full.
REQ-012 On a push when full without a simultaneous pop, the new result SHALL be dropped, FIFO contents left unchanged, and overflow set.
REQ-013 overflow_clr SHALL clear overflow on the next edge; a simultaneous new drop SHALL win and overflow stays 1.
REQ-014 out_data SHALL be stable while out_valid=1 and out_ready=0; FIFO order is strictly first-in first-out, and pointers wrap modulo FIFO_DEPTH.

Reset
REQ-015 reset=0 SHALL asynchronously force the following, with no dependency on clk:
- state IDLE, count 0, acc 0, latched N=1;
- FIFO empty, pointers 0, out_valid=0, fifo_count=0;
- overflow=0; out_data=0.
REQ-016 Reset asserted mid-window SHALL discard the partial window; reset asserted with a non-empty FIFO SHALL discard its contents.
REQ-017 The first sample after reset deassertion SHALL start a new window using the decim_sel value present at that edge.

Structure
REQ-018 Shared package fir_pkg SHALL hold:
- DATA_W constant;
- decim_sel_t enum (DECIM_1, DECIM_2, DECIM_4, DECIM_8);
- state_t enum (IDLE, ACCUM).
REQ-019 The FIFO SHALL be the sub-module fir_fifo (synchronous FIFO, depth and width parameterised, push, pop, full, empty, count, async active-low reset); decimation control and datapath stay in fir_decimator.

Verification
REQ-020 With decim_sel=2, in_valid=1 and samples 10,20,30,40: one push occurs, out_data=25, and out_valid rises 1 cycle after the 4th sample edge.
REQ-021 With decim_sel=3 and eight samples of 255: out_data=255 with no wrap. With decim_sel=1 and samples 3,4: out_data=3 (truncation).
REQ-022 With in_valid gaps inside a window (decim_sel=1: sample 8, 3 idle cycles, sample 12): exactly one result of 10.
REQ-023 With decim_sel=0, out_ready=0 and 6 samples 1..6: FIFO holds 1,2,3,4, overflow=1, and draining yields 1,2,3,4 in order. Then overflow_clr pulse: overflow=0.
REQ-024 With a full FIFO, out_ready=1 and a push on the same edge: count stays 4, overflow stays 0, and order is preserved.
REQ-025 With reset pulsed low mid-window (decim_sel=2, after 2 samples): outputs are at reset values immediately. The next 4 samples 4,4,4,4 give out_data=4, with no residue from the aborted window.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR output decimator:
//   DATA_W       default sample / result width
//   decim_sel_t  decimation factor encoding (N = 1, 2, 4, 8)
//   state_t      window state (IDLE: no partial window, ACCUM: window open)
//   decim_last   last window count (N-1) for a given decimation setting
// -----------------------------------------------------------------------------
package fir_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      DECIM_1 = 2'd0,
      DECIM_2 = 2'd1,
      DECIM_4 = 2'd2,
      DECIM_8 = 2'd3
   } decim_sel_t;

   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Window count value of the final sample in a window (N-1).
   function automatic logic [2:0] decim_last(input decim_sel_t sel);
      logic [2:0] last;
      case (sel)
         DECIM_1: last = 3'd0;
         DECIM_2: last = 3'd1;
         DECIM_4: last = 3'd3;
         default: last = 3'd7;
      endcase
      return last;
   endfunction

endpackage

// File: rtl/fir_fifo.sv
// -----------------------------------------------------------------------------
// fir_fifo
// Synchronous first-word-fall-through FIFO holding decimated results.
//
// Parameters
//   WIDTH   entry width
//   DEPTH   number of entries, power of two, at least 2
//
// Ports
//   clk        clock, all updates on posedge
//   reset      asynchronous active-low reset; empties the FIFO
//   push       write push_data this edge (ignored when full unless popping)
//   push_data  entry to write
//   pop        consume the head this edge (ignored when empty)
//   head_data  current head entry, forced to 0 while empty
//   full       DEPTH entries stored
//   empty      no entries stored
//   count      number of entries stored (0..DEPTH)
// -----------------------------------------------------------------------------
module fir_fifo
   import fir_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;

   logic push_ok;
   logic pop_ok;

   assign empty  = (count_reg == '0);
   assign full   = (count_reg == CNT_W'(DEPTH));
   assign pop_ok = pop && !empty;
   // When full, a simultaneous pop frees the head slot, which is exactly the
   // slot wr_ptr points at, so the write can go ahead on the same edge.
   assign push_ok = push && (!full || pop_ok);

   // Storage carries no reset; its contents are never observed while empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head_data = empty ? '0 : mem[rd_ptr_reg];
   assign count     = count_reg;

endmodule

// File: rtl/fir_decimator.sv
// -----------------------------------------------------------------------------
// fir_decimator
// Block-average decimator for an unsigned FIR output stream. Each window of N
// accepted samples (N = 1, 2, 4, 8 from decim_sel) produces one truncated
// average, which is queued in an output FIFO with ready/valid handshake.
//
// Parameters
//   DATA_W      sample and result width
//   FIFO_DEPTH  output FIFO entries, power of two, at least 2
//
// Ports
//   clk           clock, all updates on posedge
//   reset         asynchronous active-low reset
//   in_valid      in_data carries a sample (always accepted, no backpressure)
//   in_data       unsigned input sample
//   decim_sel     decimation factor, sampled at the first sample of a window
//   out_valid     FIFO holds at least one result
//   out_data      FIFO head (0 while empty)
//   out_ready     consumer takes the head when out_valid is also 1
//   overflow      sticky flag: a result was dropped because the FIFO was full
//   overflow_clr  clears overflow on the next edge (a new drop takes priority)
//   fifo_count    number of results currently queued
// -----------------------------------------------------------------------------
module fir_decimator #(
   parameter int DATA_W     = fir_pkg::DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   input  logic [DATA_W-1:0]             in_data,
   input  logic [1:0]                    decim_sel,
   output logic                          out_valid,
   output logic [DATA_W-1:0]             out_data,
   input  logic                          out_ready,
   output logic                          overflow,
   input  logic                          overflow_clr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   import fir_pkg::*;

   // Three extra bits hold the sum of up to eight full-scale samples.
   localparam int ACC_W = DATA_W + 3;

   // Window state
   state_t           state_reg;
   logic [2:0]       count_reg;
   logic [ACC_W-1:0] acc_reg;
   decim_sel_t       sel_reg;
   logic             overflow_reg;

   // Datapath / control
   decim_sel_t       sel_eff;
   logic [2:0]       last_count;
   logic             last_sample;
   logic [ACC_W-1:0] sum;
   logic [ACC_W-1:0] shifted;
   logic [DATA_W-1:0] result;

   // FIFO handshake
   logic             push;
   logic             pop;
   logic             drop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   // ---------------------------------------------------------------------------
   // Window datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      // A new window takes decim_sel live; an open window keeps its latched N
      // so mid-window changes on decim_sel are ignored.
      sel_eff     = (state_reg == IDLE) ? decim_sel_t'(decim_sel) : sel_reg;
      last_count  = decim_last(sel_eff);
      last_sample = (count_reg == last_count);
      sum         = acc_reg + ACC_W'(in_data);
      // Dividing by a power of two is a right shift; the average of DATA_W-bit
      // samples always fits back into DATA_W bits, so the slice is lossless.
      shifted     = sum >> sel_eff;
      result      = shifted[DATA_W-1:0];
   end

   // The completed window is pushed on the same edge that accepts its last
   // sample, so the result is visible one cycle later.
   assign push = in_valid && last_sample;

   // ---------------------------------------------------------------------------
   // Window FSM: IDLE means no partial window; ACCUM means count_reg > 0.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         count_reg <= 3'd0;
         acc_reg   <= '0;
         sel_reg   <= DECIM_1;
      end else if (in_valid) begin
         case (state_reg)
            IDLE: begin
               sel_reg <= sel_eff;
               if (last_sample) begin
                  // N = 1: every sample is a complete window.
                  state_reg <= IDLE;
                  count_reg <= 3'd0;
                  acc_reg   <= '0;
               end else begin
                  state_reg <= ACCUM;
                  count_reg <= 3'd1;
                  acc_reg   <= sum;
               end
            end
            ACCUM: begin
               if (last_sample) begin
                  state_reg <= IDLE;
                  count_reg <= 3'd0;
                  acc_reg   <= '0;
               end else begin
                  state_reg <= ACCUM;
                  count_reg <= count_reg + 3'd1;
                  acc_reg   <= sum;
               end
            end
            default: begin
               state_reg <= IDLE;
               count_reg <= 3'd0;
               acc_reg   <= '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Output FIFO and overflow tracking
   // ---------------------------------------------------------------------------
   assign pop  = !fifo_empty && out_ready;
   // A full FIFO still accepts a push when the head is popped on the same edge.
   assign drop = push && fifo_full && !pop;

   fir_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (result),
      .pop       (pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Sticky drop flag; a drop on the same edge as a clear keeps it set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow_reg <= 1'b0;
      end else if (drop) begin
         overflow_reg <= 1'b1;
      end else if (overflow_clr) begin
         overflow_reg <= 1'b0;
      end
   end

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_head;
   assign overflow  = overflow_reg;

endmodule

// File: tb/tb_fir_decimator.sv
module tb_fir_decimator;

   localparam int DW    = 8;
   localparam int DEPTH = 4;

   logic          clk;
   logic          reset;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [1:0]    decim_sel;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          overflow;
   logic          overflow_clr;
   logic [2:0]    fifo_count;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model: window sum/length and a result queue.
   int m_q[$];
   int m_win_sum;
   int m_win_len;
   int m_win_n;
   bit m_ovf;

   fir_decimator #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .decim_sel    (decim_sel),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .overflow     (overflow),
      .overflow_clr (overflow_clr),
      .fifo_count   (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_clear();
      m_q.delete();
      m_win_sum = 0;
      m_win_len = 0;
      m_win_n   = 1;
      m_ovf     = 1'b0;
   endtask

   // Advance the model with the inputs the next posedge will see, then
   // let that edge happen and return on the following negedge.
   task automatic tick();
      bit pop, push, drop;
      int res, sz;
      pop  = (m_q.size() > 0) && out_ready;
      push = 1'b0;
      res  = 0;
      if (in_valid) begin
         if (m_win_len == 0) m_win_n = 1 << decim_sel;
         m_win_sum += int'(in_data);
         m_win_len++;
         if (m_win_len == m_win_n) begin
            push      = 1'b1;
            res       = m_win_sum / m_win_n;
            m_win_sum = 0;
            m_win_len = 0;
         end
      end
      sz   = m_q.size();
      drop = push && (sz >= DEPTH) && !pop;
      if (pop) void'(m_q.pop_front());
      if (push && !drop) m_q.push_back(res);
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input int d);
      in_valid = 1'b1;
      in_data  = DW'(d);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      in_valid     = 1'b0;
      in_data      = '0;
      out_ready    = 1'b0;
      overflow_clr = 1'b0;
      reset        = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      in_valid = 1'b0; in_data = '0; decim_sel = 2'd0;
      out_ready = 1'b0; overflow_clr = 1'b0;
      reset = 1'b0;
      model_clear();
      #2;
      n_compared++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 || out_data !== 8'd0) begin
         n_mismatched++;
         $display("FAIL reset_async: valid=%b count=%0d ovf=%b data=%0d want 0/0/0/0", out_valid, fifo_count, overflow, out_data);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      tick();
      n_compared++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0) begin
         n_mismatched++;
         $display("FAIL reset_release: valid=%b count=%0d ovf=%b want 0/0/0", out_valid, fifo_count, overflow);
      end
      $display("test_reset done");
   endtask

   task automatic test_avg4();
      do_reset();
      decim_sel = 2'd2;
      send(10); send(20); send(30);
      n_compared++;
      if (out_valid !== 1'b0) begin
         n_mismatched++;
         $display("FAIL avg4_early: out_valid=%b want 0", out_valid);
      end
      send(40);
      n_compared++;
      if (out_valid !== 1'b1 || fifo_count !== 3'd1) begin
         n_mismatched++;
         $display("FAIL avg4_latency: out_valid=%b count=%0d want 1/1", out_valid, fifo_count);
      end
      n_compared++;
      if (out_data !== 8'd25) begin
         n_mismatched++;
         $display("FAIL avg4_data: got %0d want 25", out_data);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_compared++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
         n_mismatched++;
         $display("FAIL avg4_pop: out_valid=%b count=%0d want 0/0", out_valid, fifo_count);
      end
      $display("test_avg4 done");
   endtask

   task automatic test_max_and_trunc();
      do_reset();
      decim_sel = 2'd3;
      for (int i = 0; i < 8; i++) send(255);
      n_compared++;
      if (out_valid !== 1'b1 || out_data !== 8'd255) begin
         n_mismatched++;
         $display("FAIL max8: valid=%b data=%0d want 1/255", out_valid, out_data);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      decim_sel = 2'd1;
      send(3); send(4);
      n_compared++;
      if (out_valid !== 1'b1 || out_data !== 8'd3) begin
         n_mismatched++;
         $display("FAIL trunc2: valid=%b data=%0d want 1/3", out_valid, out_data);
      end
      $display("test_max_and_trunc done");
   endtask

   task automatic test_gaps();
      do_reset();
      decim_sel = 2'd1;
      send(8);
      decim_sel = 2'd3;   // mid-window change must be ignored
      repeat (3) tick();
      n_compared++;
      if (fifo_count !== 3'd0) begin
         n_mismatched++;
         $display("FAIL gaps_hold: count=%0d want 0", fifo_count);
      end
      send(12);
      n_compared++;
      if (fifo_count !== 3'd1 || out_data !== 8'd10) begin
         n_mismatched++;
         $display("FAIL gaps_result: count=%0d data=%0d want 1/10", fifo_count, out_data);
      end
      $display("test_gaps done");
   endtask

   task automatic test_overflow();
      do_reset();
      decim_sel = 2'd0;
      for (int i = 1; i <= 6; i++) send(i);
      n_compared++;
      if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
         n_mismatched++;
         $display("FAIL ovf_set: count=%0d ovf=%b want 4/1", fifo_count, overflow);
      end
      // Clear together with another drop: drop wins.
      overflow_clr = 1'b1;
      send(7);
      overflow_clr = 1'b0;
      n_compared++;
      if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
         n_mismatched++;
         $display("FAIL ovf_clr_vs_drop: ovf=%b count=%0d want 1/4", overflow, fifo_count);
      end
      for (int i = 1; i <= 4; i++) begin
         n_compared++;
         if (out_valid !== 1'b1 || out_data !== DW'(i)) begin
            n_mismatched++;
            $display("FAIL ovf_drain[%0d]: valid=%b data=%0d want 1/%0d", i, out_valid, out_data, i);
         end
         out_ready = 1'b1; tick(); out_ready = 1'b0;
      end
      n_compared++;
      if (out_valid !== 1'b0) begin
         n_mismatched++;
         $display("FAIL ovf_empty: out_valid=%b want 0", out_valid);
      end
      overflow_clr = 1'b1; tick(); overflow_clr = 1'b0;
      n_compared++;
      if (overflow !== 1'b0) begin
         n_mismatched++;
         $display("FAIL ovf_clear: ovf=%b want 0", overflow);
      end
      $display("test_overflow done");
   endtask

   task automatic test_full_push_pop();
      do_reset();
      decim_sel = 2'd0;
      for (int i = 11; i <= 14; i++) send(i);
      out_ready = 1'b1;
      send(15);
      out_ready = 1'b0;
      n_compared++;
      if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
         n_mismatched++;
         $display("FAIL full_pushpop: count=%0d ovf=%b want 4/0", fifo_count, overflow);
      end
      for (int i = 12; i <= 15; i++) begin
         n_compared++;
         if (out_data !== DW'(i)) begin
            n_mismatched++;
            $display("FAIL full_order[%0d]: data=%0d want %0d", i, out_data, i);
         end
         out_ready = 1'b1; tick(); out_ready = 1'b0;
      end
      $display("test_full_push_pop done");
   endtask

   task automatic test_reset_midwindow();
      do_reset();
      decim_sel = 2'd0;
      for (int i = 0; i < 5; i++) send(50);
      decim_sel = 2'd2;
      send(100); send(200);
      #1 reset = 1'b0;
      #1;
      n_compared++;
      if (out_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b0 || out_data !== 8'd0) begin
         n_mismatched++;
         $display("FAIL midreset_async: valid=%b count=%0d ovf=%b data=%0d want 0/0/0/0", out_valid, fifo_count, overflow, out_data);
      end
      model_clear();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) send(4);
      n_compared++;
      if (fifo_count !== 3'd1 || out_data !== 8'd4) begin
         n_mismatched++;
         $display("FAIL midreset_fresh: count=%0d data=%0d want 1/4", fifo_count, out_data);
      end
      $display("test_reset_midwindow done");
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         in_data      = DW'($urandom);
         decim_sel    = 2'($urandom);
         out_ready    = ($urandom_range(0, 2) == 0);
         overflow_clr = ($urandom_range(0, 15) == 0);
         tick();
         n_compared++;
         if (out_valid !== (m_q.size() > 0) || fifo_count !== 3'(m_q.size()) || overflow !== m_ovf) begin
            n_mismatched++;
            $display("FAIL rand_status[%0d]: valid=%b count=%0d ovf=%b want %b/%0d/%b",
                     c, out_valid, fifo_count, overflow, (m_q.size() > 0), m_q.size(), m_ovf);
         end
         if (m_q.size() > 0) begin
            n_compared++;
            if (out_data !== DW'(m_q[0])) begin
               n_mismatched++;
               $display("FAIL rand_data[%0d]: data=%0d want %0d", c, out_data, m_q[0]);
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b0; overflow_clr = 1'b0;
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_avg4();
      test_max_and_trunc();
      test_gaps();
      test_overflow();
      test_full_push_pop();
      test_reset_midwindow();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
